// File: rtl/ultrasonic_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonic_shift_pkg
//  Description : Shared register offsets, AXI response codes and word type
//                for the ultrasonic phase-shift AXI4-Lite slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package ultrasonic_shift_pkg;

    // Word offsets (byte address bits [4:2])
    localparam logic [2:0] REG_SHIFT0  = 3'd0;
    localparam logic [2:0] REG_CTRL    = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [31:0] shift_word_t;

endpackage
`default_nettype wire

// File: rtl/ultrasonic_shift_dbuf.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonic_shift_dbuf
//  Description : Shadow/active phase-shift banks. Software writes the shadow
//                bank; a pending commit copies it to the active bank on the
//                next frame_sync pulse so outputs change only at a PWM period
//                boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_shift_dbuf
    import ultrasonic_shift_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        shadow_we,
    input  logic [2:0]                  shadow_idx,
    input  shift_word_t                 wr_data,
    input  logic [3:0]                  wr_strb,
    input  logic                        commit_set,
    input  logic                        frame_sync,
    output logic [NUM_CH*32-1:0]        shadow_flat,
    output logic                        commit_pending,
    output logic [NUM_CH*PHASE_W-1:0]   shift,
    output logic                        shift_update
);

    logic transfer;
    logic transfer_q;

    // Copy happens only on a frame boundary with a commit already latched;
    // a commit arriving in the same cycle waits for the next boundary.
    assign transfer = frame_sync & commit_pending;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            shift_word_t        shadow_q;
            logic [PHASE_W-1:0] active_q;

            // Byte-enabled software write into this channel's shadow word
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    shadow_q <= '0;
                end else if (shadow_we && (shadow_idx == 3'(k))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) shadow_q[8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end

            // Active copy samples the pre-write shadow value on transfer
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    active_q <= '0;
                end else if (transfer) begin
                    active_q <= shadow_q[PHASE_W-1:0];
                end
            end

            assign shadow_flat[k*32 +: 32]        = shadow_q;
            assign shift[k*PHASE_W +: PHASE_W]    = active_q;
        end
    endgenerate

    // Commit request latches until consumed; a new request wins over clearing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
        end else if (commit_set) begin
            commit_pending <= 1'b1;
        end else if (transfer) begin
            commit_pending <= 1'b0;
        end
    end

    // Update strobe lands the cycle after the active bank shows new values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            transfer_q   <= 1'b0;
            shift_update <= 1'b0;
        end else begin
            transfer_q   <= transfer;
            shift_update <= transfer_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ultrasonic_shift_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonic_shift_axil_slave
//  Description : AXI4-Lite slave for the ultrasonic phase-shift controller.
//                Independent AW/W acceptance, single outstanding write,
//                latency-1 reads, double-buffered shift outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_shift_axil_slave
    import ultrasonic_shift_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_CH             = 4,
    parameter int PHASE_W            = 16
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic                            frame_sync_i,
    output logic [NUM_CH*PHASE_W-1:0]       shift_o,
    output logic                            shift_update_o
);

    localparam logic [2:0] W_IDLE      = 3'd0;
    localparam logic [2:0] W_HAVE_AW   = 3'd1;
    localparam logic [2:0] W_HAVE_W    = 3'd2;
    localparam logic [2:0] W_HAVE_BOTH = 3'd3;
    localparam logic [2:0] W_RESP      = 3'd4;

    localparam logic [0:0] R_IDLE      = 1'b0;
    localparam logic [0:0] R_RESP      = 1'b1;

    logic [2:0]           wstate;
    logic [0:0]           rstate;
    logic [2:0]           aw_idx;
    shift_word_t          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 aw_hs, w_hs, ar_hs;
    logic                 aw_open, w_open;
    logic                 wr_shadow, wr_ctrl, wr_apply;
    logic [2:0]           ar_idx;
    shift_word_t          rd_data;
    logic [1:0]           rd_resp;
    logic [NUM_CH*32-1:0] shadow_flat;
    logic                 commit_pending;
    logic                 unused_inputs;

    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign aw_hs   = s00_axi_awvalid & s00_axi_awready;
    assign w_hs    = s00_axi_wvalid  & s00_axi_wready;
    assign ar_hs   = s00_axi_arvalid & s00_axi_arready;
    assign aw_open = (wstate == W_IDLE) || (wstate == W_HAVE_W);
    assign w_open  = (wstate == W_IDLE) || (wstate == W_HAVE_AW);
    assign ar_idx  = s00_axi_araddr[4:2];

    // Write target decode from the captured address
    always_comb begin
        wr_shadow = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (aw_idx == REG_SHIFT0 + 3'(k)) wr_shadow = 1'b1;
        end
        wr_ctrl  = (aw_idx == REG_CTRL);
        wr_apply = (wstate == W_HAVE_BOTH);
    end

    // Write channel: skid AW and W separately, apply once both held, then B
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            wstate          <= W_IDLE;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
            aw_idx          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
        end else begin
            s00_axi_awready <= s00_axi_awvalid & ~s00_axi_awready & aw_open;
            s00_axi_wready  <= s00_axi_wvalid  & ~s00_axi_wready  & w_open;
            if (aw_hs) aw_idx <= s00_axi_awaddr[4:2];
            if (w_hs) begin
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
            case (wstate)
                W_IDLE: begin
                    if (aw_hs && w_hs) wstate <= W_HAVE_BOTH;
                    else if (aw_hs)    wstate <= W_HAVE_AW;
                    else if (w_hs)     wstate <= W_HAVE_W;
                end
                W_HAVE_AW: if (w_hs)  wstate <= W_HAVE_BOTH;
                W_HAVE_W:  if (aw_hs) wstate <= W_HAVE_BOTH;
                W_HAVE_BOTH: begin
                    s00_axi_bvalid <= 1'b1;
                    s00_axi_bresp  <= (wr_shadow || wr_ctrl) ? RESP_OKAY : RESP_SLVERR;
                    wstate         <= W_RESP;
                end
                W_RESP: begin
                    if (s00_axi_bready) begin
                        s00_axi_bvalid <= 1'b0;
                        wstate         <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read data/response mux evaluated at the AR handshake
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ar_idx == REG_SHIFT0 + 3'(k)) begin
                rd_data = shadow_flat[k*32 +: 32];
                rd_resp = RESP_OKAY;
            end
        end
        if (ar_idx == REG_CTRL) rd_resp = RESP_OKAY;
        if (ar_idx == REG_STATUS) begin
            rd_data[0]    = commit_pending;
            rd_data[15:8] = 8'(NUM_CH);
            rd_resp       = RESP_OKAY;
        end
    end

    // Read channel: one AR at a time, data registered for latency-1 response
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            rstate          <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            s00_axi_arready <= s00_axi_arvalid & ~s00_axi_arready & (rstate == R_IDLE);
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        s00_axi_rvalid <= 1'b1;
                        s00_axi_rdata  <= rd_data;
                        s00_axi_rresp  <= rd_resp;
                        rstate         <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s00_axi_rready) begin
                        s00_axi_rvalid <= 1'b0;
                        rstate         <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    ultrasonic_shift_dbuf #(
        .NUM_CH  (NUM_CH),
        .PHASE_W (PHASE_W)
    ) u_dbuf (
        .clk            (s00_axi_aclk),
        .rst_n          (s00_axi_aresetn),
        .shadow_we      (wr_apply & wr_shadow),
        .shadow_idx     (aw_idx - REG_SHIFT0),
        .wr_data        (wdata_q),
        .wr_strb        (wstrb_q),
        .commit_set     (wr_apply & wr_ctrl & wstrb_q[0] & wdata_q[0]),
        .frame_sync     (frame_sync_i),
        .shadow_flat    (shadow_flat),
        .commit_pending (commit_pending),
        .shift          (shift_o),
        .shift_update   (shift_update_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_shift_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ultrasonic_shift_axil_slave
//  Description : Self-checking bench: constant vector table, directed corner
//                sequences and random traffic against a register-map model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_shift_axil_slave;

    localparam int NUM_CH  = 4;
    localparam int PHASE_W = 16;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        frame_sync = 0;
    logic        awready, wready, bvalid, arready, rvalid, shift_update;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NUM_CH*PHASE_W-1:0] shift_o;

    always #5 clk = ~clk;

    ultrasonic_shift_axil_slave dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .frame_sync_i(frame_sync), .shift_o(shift_o),
        .shift_update_o(shift_update)
    );

    int checks = 0;
    int errors = 0;

    // Register-map model
    logic [31:0]        m_shadow [NUM_CH];
    logic [PHASE_W-1:0] m_active [NUM_CH];
    logic               m_pending;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_pending = 1'b0;
    endtask

    function automatic logic [63:0] m_shift();
        logic [63:0] r = '0;
        for (int k = 0; k < NUM_CH; k++) r[k*PHASE_W +: PHASE_W] = m_active[k];
        return r;
    endfunction

    function automatic logic [1:0] m_wresp(input logic [4:0] a);
        int w = a / 4;
        return (w < NUM_CH || w == 4) ? 2'b00 : 2'b10;
    endfunction

    task automatic m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int w = a / 4;
        if (w < NUM_CH) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_shadow[w][8*b +: 8] = d[8*b +: 8];
        end else if (w == 4 && s[0] && d[0]) begin
            m_pending = 1'b1;
        end
    endtask

    task automatic m_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int w = a / 4;
        d = '0;
        r = 2'b00;
        if (w < NUM_CH)      d = m_shadow[w];
        else if (w == 5)     d = 32'(NUM_CH * 256) + 32'(m_pending);
        else if (w != 4)     r = 2'b10;
    endtask

    task automatic m_frame(output bit xfer);
        xfer = m_pending;
        if (m_pending) begin
            for (int k = 0; k < NUM_CH; k++) m_active[k] = m_shadow[k][PHASE_W-1:0];
            m_pending = 1'b0;
        end
    endtask

    task automatic pulse_fs();
        bit x;
        m_frame(x);
        frame_sync = 1'b1;
        @(posedge clk); #1;
        frame_sync = 1'b0;
        check("fs_shift", shift_o, m_shift());
        check("fs_update_early", shift_update, 1'b0);
        @(posedge clk); #1;
        check("fs_update_pulse", shift_update, x);
        @(posedge clk); #1;
        check("fs_update_end", shift_update, 1'b0);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input bit fs_apply, input int b_delay,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs, x;
        int cyc = 0;
        awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 64) begin
            if (cyc >= w_lead && !aw_done) awvalid = 1'b1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_handshake", {aw_done, w_done}, 2'b11);
        if (fs_apply) m_frame(x);
        m_write(a, d, s);
        if (fs_apply) frame_sync = 1'b1;
        @(posedge clk); #1;
        frame_sync = 1'b0;
        if (fs_apply) check("fs_apply_shift", shift_o, m_shift());
        check("bvalid_latency", bvalid, 1'b1);
        if (b_delay > 0) begin awaddr = 5'h10; awvalid = 1'b1; end
        for (int i = 0; i < b_delay; i++) begin
            @(posedge clk); #1;
            check("bvalid_hold", bvalid, 1'b1);
            check("awready_blocked", awready, 1'b0);
        end
        bready = 1'b1;
        cyc = 0;
        while (!bvalid && cyc < 32) begin @(posedge clk); #1; cyc++; end
        resp = bresp;
        check("bvalid_seen", bvalid, 1'b1);
        @(posedge clk); #1;
        bready = 1'b0; awvalid = 1'b0;
        check("bvalid_clear", bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [4:0] a, input int r_delay,
                            output logic [31:0] d, output logic [1:0] resp);
        bit done = 0;
        int cyc = 0;
        logic [31:0] d0;
        araddr = a; arvalid = 1'b1;
        while (!done && cyc < 64) begin
            done = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        check("ar_handshake", done, 1'b1);
        check("rvalid_latency", rvalid, 1'b1);
        d0 = rdata;
        for (int i = 0; i < r_delay; i++) begin
            @(posedge clk); #1;
            check("rdata_stable", {rvalid, rdata}, {1'b1, d0});
        end
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 1'b0);
    endtask

    typedef struct {
        bit          is_write;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        bit          hs;
        int          cyc;

        tbl[0]  = '{1, 5'h00, 32'h1,        4'hF, 2'b00, 32'h0};
        tbl[1]  = '{1, 5'h04, 32'h2,        4'hF, 2'b00, 32'h0};
        tbl[2]  = '{1, 5'h08, 32'h3,        4'hF, 2'b00, 32'h0};
        tbl[3]  = '{1, 5'h0C, 32'h4,        4'hF, 2'b00, 32'h0};
        tbl[4]  = '{0, 5'h00, 32'h0,        4'h0, 2'b00, 32'h1};
        tbl[5]  = '{0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h2};
        tbl[6]  = '{0, 5'h08, 32'h0,        4'h0, 2'b00, 32'h3};
        tbl[7]  = '{0, 5'h0C, 32'h0,        4'h0, 2'b00, 32'h4};
        tbl[8]  = '{1, 5'h18, 32'hDEADBEEF, 4'hF, 2'b10, 32'h0};
        tbl[9]  = '{1, 5'h14, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        tbl[10] = '{0, 5'h1C, 32'h0,        4'h0, 2'b10, 32'h0};
        tbl[11] = '{0, 5'h18, 32'h0,        4'h0, 2'b10, 32'h0};
        tbl[12] = '{0, 5'h10, 32'h0,        4'h0, 2'b00, 32'h0};
        tbl[13] = '{0, 5'h14, 32'h0,        4'h0, 2'b00, 32'h0400};
        tbl[14] = '{0, 5'h0D, 32'h0,        4'h0, 2'b00, 32'h4};
        tbl[15] = '{0, 5'h03, 32'h0,        4'h0, 2'b00, 32'h1};

        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_valid", {awready, wready, bvalid, arready, rvalid}, 5'b0);
        check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
        check("rst_shift", {shift_update, shift_o}, 65'h0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].is_write) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, 0, r);
                check($sformatf("tbl%0d_bresp", i), r, tbl[i].exp_resp);
            end else begin
                axi_read(tbl[i].addr, 0, d, r);
                check($sformatf("tbl%0d_rresp", i), r, tbl[i].exp_resp);
                check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rdata);
            end
        end
        check("tbl_shift_idle", shift_o, 64'h0);

        // W leads AW by 3 cycles, single byte lane
        axi_write(5'h04, 32'hAABBCCDD, 4'b0010, 3, 0, 0, r);
        check("wlead_bresp", r, 2'b00);
        axi_read(5'h04, 0, d, r);
        check("wlead_rdata", d, 32'h0000CC02);

        // Commit then frame boundary
        axi_write(5'h00, 32'h1234, 4'hF, 0, 0, 0, r);
        axi_write(5'h10, 32'h1, 4'hF, 0, 0, 0, r);
        axi_read(5'h14, 0, d, r);
        check("status_pending", d, 32'h0401);
        pulse_fs();
        check("commit_ch0", shift_o[15:0], 16'h1234);
        axi_read(5'h14, 0, d, r);
        check("status_cleared", d, 32'h0400);

        // Commit coinciding with frame_sync waits for the next one
        axi_write(5'h00, 32'h5678, 4'hF, 0, 0, 0, r);
        axi_write(5'h10, 32'h1, 4'hF, 0, 1, 0, r);
        check("same_cycle_no_xfer", shift_o[15:0], 16'h1234);
        axi_read(5'h14, 1, d, r);
        check("same_cycle_pending", d, 32'h0401);
        pulse_fs();
        check("next_fs_xfer", shift_o[15:0], 16'h5678);

        // Repeated commit yields a single transfer
        axi_write(5'h10, 32'h1, 4'hF, 0, 0, 0, r);
        axi_write(5'h10, 32'h1, 4'hF, 0, 0, 0, r);
        axi_write(5'h00, 32'h9ABC, 4'hF, 0, 0, 0, r);
        pulse_fs();
        check("repeat_xfer", shift_o[15:0], 16'h9ABC);
        pulse_fs();

        // Shadow write in the transfer cycle: active takes the old shadow
        axi_write(5'h10, 32'h1, 4'hF, 0, 0, 0, r);
        axi_write(5'h00, 32'h1111, 4'hF, 1, 1, 0, r);
        check("prewrite_active", shift_o[15:0], 16'h9ABC);
        axi_read(5'h00, 0, d, r);
        check("prewrite_shadow", d, 32'h1111);

        // Unmapped write with bready withheld
        axi_write(5'h18, 32'h12345678, 4'hF, 0, 0, 5, r);
        check("unmapped_bresp", r, 2'b10);
        axi_read(5'h08, 2, d, r);
        check("unmapped_noeffect", d, 32'h3);

        // Random traffic against the model
        for (int n = 0; n < 250; n++) begin
            logic [4:0]  a  = 5'($urandom_range(0, 31));
            logic [31:0] dd = $urandom;
            logic [3:0]  s  = 4'($urandom_range(0, 15));
            int          op = $urandom_range(0, 9);
            if (op < 4) begin
                if (a[4:2] == 3'd4) dd[0] = ($urandom_range(0, 1) == 1);
                axi_write(a, dd, s, $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                          $urandom_range(0, 2), r);
                check("rnd_bresp", r, m_wresp(a));
            end else if (op < 8) begin
                axi_read(a, $urandom_range(0, 2), d, r);
                m_read(a, ed, er);
                check("rnd_rresp", r, er);
                check("rnd_rdata", d, ed);
            end else begin
                pulse_fs();
            end
            check("rnd_shift", shift_o, m_shift());
        end

        // Reset in the middle of a write and a pending read response
        awaddr = 5'h00; awvalid = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && cyc < 16) begin
            hs = awready;
            @(posedge clk); #1;
            cyc++;
        end
        awvalid = 1'b0;
        araddr = 5'h00; arvalid = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && cyc < 16) begin
            hs = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        check("pre_rst_rvalid", rvalid, 1'b1);
        aresetn = 1'b0;
        @(posedge clk); #1;
        check("midrst_valids", {awready, wready, bvalid, arready, rvalid}, 5'b0);
        check("midrst_shift", {shift_update, shift_o}, 65'h0);
        aresetn = 1'b1;
        m_reset();
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_bresp", bvalid, 1'b0);
        end
        axi_read(5'h14, 0, d, r);
        check("midrst_status", d, 32'h0400);
        axi_read(5'h00, 0, d, r);
        check("midrst_shadow", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
